uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of uart_rx. Captures each completed receive frame (9-bit word plus frame and parity error status) on the receiver's done indication and stores it in a first-word-fall-through FIFO. Presents entries to the register/bus side through a valid/ready handshake. Drives the almost-full signal back to uart_rx, which uses it for hardware RTS flow control.

Parameters:
DEPTH, 16, number of entries; power of two, >= 4
ALMFULL_LEVEL, 12, o_almfull asserts when occupancy >= this value; range 1..DEPTH
TIMEOUT_CHARS, 4, idle character times before o_timeout asserts (optional feature only)

Ports:
i_clk  input  1  clock
i_nrst  input  1  asynchronous active-low reset
i_rx_done  input  1  receiver frame-complete indication; may stay high for more than one cycle
i_rx_word  input  9  received data[7:0] plus parity bit[8]
i_rx_frame_error  input  1  frame (stop bit) error for the current frame
i_rx_parity_error  input  1  parity error for the current frame
i_parity_enable  input  1  when 0, stored parity-error flag is forced to 0
i_bit_length  input  32  clocks per bit; used by the timeout feature
i_flush  input  1  synchronous FIFO clear
o_rd_valid  output  1  head entry available
i_rd_ready  input  1  consumer accepts head entry
o_rd_data  output  11  {parity_err, frame_err, word[8:0]} of head entry
o_count  output  $clog2(DEPTH)+1  current occupancy
o_empty  output  1  occupancy == 0
o_full  output  1  occupancy == DEPTH
o_almfull  output  1  occupancy >= ALMFULL_LEVEL; connects to the receiver's FIFO almost-full input
o_overflow  output  1  sticky: a frame was dropped because the FIFO was full
o_timeout  output  1  receive idle timeout with data pending

Behaviour:
- Reset values: pointers 0, o_count 0, o_empty 1, o_full 0, o_almfull 0, o_rd_valid 0, o_overflow 0, o_timeout 0, o_rd_data 0.
- Push event: rising edge of i_rx_done, detected with a registered copy of i_rx_done (reset 0). Exactly one push per frame, however long i_rx_done stays high.
- Entry captured on the push cycle: {i_rx_parity_error & i_parity_enable, i_rx_frame_error, i_rx_word}.
- Pop: i_rd_ready && o_rd_valid. o_rd_valid = !o_empty. o_rd_data is the head entry, driven combinationally from storage.
- Latency: a pushed entry is visible on o_rd_valid/o_rd_data the next cycle.
- Push while full and no pop in the same cycle: entry dropped, contents unchanged, o_overflow set.
- Push and pop in the same cycle: both performed, o_count unchanged. This includes the full case, where the push is accepted and no overflow is flagged. Push and pop with the FIFO empty is not possible, because o_rd_valid = 0.
- Pointers are $clog2(DEPTH) bits and wrap naturally; o_count is tracked separately.
- o_count, o_empty, o_full and o_almfull are registered and updated in the same cycle as the pointers.
- i_flush: pointers, count and o_overflow cleared next cycle; o_timeout cleared. Any push or pop in the flush cycle is ignored. The push edge detector keeps sampling, so a done level that is still high after the flush does not re-push.
- o_rd_data contents are don't-care when o_rd_valid = 0.
- Asynchronous reset mid-operation: all state returns to the reset values immediately.

Optional Feature:
Macro UART_RX_FIFO_TIMEOUT_EN.
- Defined:
  - A bit-period counter counts up to i_bit_length (sampled at each period start) while the FIFO is non-empty.
  - A character counter increments once per 10 completed bit periods.
  - o_timeout sets when the character counter reaches TIMEOUT_CHARS.
  - Both counters and o_timeout clear on any push, pop, flush, or while the FIFO is empty.
  - o_timeout is a level, held until cleared.
- Not defined: o_timeout is tied to 0, no counter logic is generated, and the port is still present.

Test Plan:
- Reset, then push 3 frames (0x041, 0x142, 0x043, no errors) with i_rd_ready = 0 -> o_count = 3, o_rd_data = 0x041; set i_rd_ready = 1 -> reads 0x041, 0x142, 0x043 in consecutive cycles, then o_empty = 1.
- Hold i_rx_done high for 5 cycles -> exactly one entry written, o_count = 1.
- DEPTH = 16, ALMFULL_LEVEL = 12: push 12 frames -> o_almfull = 1 on the cycle after the 12th push; push 4 more -> o_full = 1; push a 17th -> o_overflow = 1, o_count = 16, head unchanged; pop one -> o_overflow stays 1 until i_flush.
- Full FIFO with push and pop in the same cycle -> o_count stays 16, o_overflow stays 0, new entry read out last.
- Push with frame_err = 1 and parity_err = 1: with i_parity_enable = 0 -> o_rd_data[10:9] = 2'b01; with i_parity_enable = 1 -> o_rd_data[10:9] = 2'b11.
- UART_RX_FIFO_TIMEOUT_EN defined, i_bit_length = 8, TIMEOUT_CHARS = 4, one entry pending, no activity -> o_timeout asserts after about 4*10*9 cycles (±1 character time accepted); a pop clears it next cycle.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side FWFT buffer between uart_rx and the register/bus side.
// Each frame is captured once, on the rising edge of i_rx_done. Entries are read out
// through a valid/ready handshake, and o_almfull goes back to uart_rx for RTS flow control.
// Optional feature: define UART_RX_FIFO_TIMEOUT_EN to build the receive idle timeout.
// Without it, o_timeout is tied low and no counter logic is built.
module uart_rx_fifo #(
  parameter int DEPTH         = 16,
  parameter int ALMFULL_LEVEL = 12,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic                     i_clk,
  input  logic                     i_nrst,
  input  logic                     i_rx_done,
  input  logic [8:0]               i_rx_word,
  input  logic                     i_rx_frame_error,
  input  logic                     i_rx_parity_error,
  input  logic                     i_parity_enable,
  input  logic [31:0]              i_bit_length,
  input  logic                     i_flush,
  output logic                     o_rd_valid,
  input  logic                     i_rd_ready,
  output logic [10:0]              o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_almfull,
  output logic                     o_overflow,
  output logic                     o_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [10:0]   mem [DEPTH];
  logic          rx_done_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          almfull_q, almfull_d;
  logic          overflow_q, overflow_d;

  logic          push_ev;
  logic          pop_req;
  logic          do_push;
  logic          do_pop;
  logic [10:0]   entry;

  assign push_ev = i_rx_done & ~rx_done_q;
  assign pop_req = i_rd_ready & ~empty_q;
  assign do_pop  = pop_req & ~i_flush;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_ev & ~i_flush & (~full_q | pop_req);
  assign entry   = {i_rx_parity_error & i_parity_enable, i_rx_frame_error, i_rx_word};

  // Next-state for pointers, occupancy and flags; flush overrides any push or pop.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (i_flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
      if (push_ev && full_q && !pop_req) overflow_d = 1'b1;
    end
    empty_d   = (count_d == '0);
    full_d    = (count_d == CW'(DEPTH));
    almfull_d = (count_d >= CW'(ALMFULL_LEVEL));
  end

  // Control state register. The edge detector keeps sampling through a flush.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rx_done_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      almfull_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
      rx_done_q  <= i_rx_done;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      almfull_q  <= almfull_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage write port.
  // NOTE: storage has no reset. The read path is gated by empty, so stale contents never reach o_rd_data.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr_q] <= entry;
  end

  assign o_rd_valid = ~empty_q;
  assign o_rd_data  = empty_q ? 11'd0 : mem[rd_ptr_q];
  assign o_count    = count_q;
  assign o_empty    = empty_q;
  assign o_full     = full_q;
  assign o_almfull  = almfull_q;
  assign o_overflow = overflow_q;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [31:0] bit_cnt_q, bit_cnt_d;
  logic [31:0] bit_len_q, bit_len_d;
  logic [3:0]  per_cnt_q, per_cnt_d;
  logic [31:0] char_cnt_q, char_cnt_d;
  logic        timeout_q, timeout_d;
  logic [31:0] limit;
  logic        idle_clear;

  assign idle_clear = push_ev | do_pop | i_flush | empty_q;
  // The bit length is sampled at the start of each period.
  assign limit      = (bit_cnt_q == '0) ? i_bit_length : bit_len_q;

  // Idle timer: bit periods roll up into characters; any FIFO activity restarts it.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    bit_len_d  = bit_len_q;
    per_cnt_d  = per_cnt_q;
    char_cnt_d = char_cnt_q;
    timeout_d  = timeout_q;
    if (idle_clear) begin
      bit_cnt_d  = '0;
      bit_len_d  = '0;
      per_cnt_d  = '0;
      char_cnt_d = '0;
      timeout_d  = 1'b0;
    end else begin
      if (bit_cnt_q == '0) bit_len_d = i_bit_length;
      if (bit_cnt_q >= limit) begin
        bit_cnt_d = '0;
        if (per_cnt_q == 4'd9) begin
          per_cnt_d = '0;
          if (!timeout_q) char_cnt_d = char_cnt_q + 32'd1;
        end else begin
          per_cnt_d = per_cnt_q + 4'd1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 32'd1;
      end
      if (char_cnt_q >= 32'(TIMEOUT_CHARS)) timeout_d = 1'b1;
    end
  end

  // Idle timer state register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      bit_cnt_q  <= '0;
      bit_len_q  <= '0;
      per_cnt_q  <= '0;
      char_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      bit_len_q  <= bit_len_d;
      per_cnt_q  <= per_cnt_d;
      char_cnt_q <= char_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  logic [31:0] unused_bit_length;
  assign unused_bit_length = i_bit_length;
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, ALMFULL_LEVEL=12).
// A queue holds the expected entries: they are pushed when a frame is driven and popped when one is read.
module tb_uart_rx_fifo;

  logic        i_clk = 1'b0;
  logic        i_nrst;
  logic        i_rx_done;
  logic [8:0]  i_rx_word;
  logic        i_rx_frame_error;
  logic        i_rx_parity_error;
  logic        i_parity_enable;
  logic [31:0] i_bit_length;
  logic        i_flush;
  logic        o_rd_valid;
  logic        i_rd_ready;
  logic [10:0] o_rd_data;
  logic [4:0]  o_count;
  logic        o_empty;
  logic        o_full;
  logic        o_almfull;
  logic        o_overflow;
  logic        o_timeout;

  int checks   = 0;
  int failures = 0;
  logic [10:0] sb[$];
  logic [10:0] head;

  uart_rx_fifo #(.DEPTH(16), .ALMFULL_LEVEL(12), .TIMEOUT_CHARS(4)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_rx_done(i_rx_done), .i_rx_word(i_rx_word),
    .i_rx_frame_error(i_rx_frame_error), .i_rx_parity_error(i_rx_parity_error),
    .i_parity_enable(i_parity_enable), .i_bit_length(i_bit_length), .i_flush(i_flush),
    .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data),
    .o_count(o_count), .o_empty(o_empty), .o_full(o_full), .o_almfull(o_almfull),
    .o_overflow(o_overflow), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One frame: done high for one cycle, then low for one cycle.
  task automatic push(input logic [8:0] w, input logic fe, input logic pe, input bit accept);
    i_rx_word         = w;
    i_rx_frame_error  = fe;
    i_rx_parity_error = pe;
    i_rx_done         = 1'b1;
    if (accept) sb.push_back({pe & i_parity_enable, fe, w});
    tick();
    i_rx_done = 1'b0;
    tick();
  endtask

  // Read everything back with ready held high, checking data order against the queue.
  task automatic drain(input string tag);
    i_rd_ready = 1'b1;
    for (int n = 0; n < 20 && sb.size() > 0; n++) begin
      head = sb.pop_front();
      check({tag, "_valid"}, 32'(o_rd_valid), 32'd1);
      check({tag, "_data"}, 32'(o_rd_data), 32'(head));
      tick();
    end
    i_rd_ready = 1'b0;
    check({tag, "_empty"}, 32'(o_empty), 32'd1);
  endtask

  initial begin
    i_nrst = 1'b0; i_rx_done = 1'b0; i_rx_word = '0; i_rx_frame_error = 1'b0;
    i_rx_parity_error = 1'b0; i_parity_enable = 1'b1; i_bit_length = 32'd8;
    i_flush = 1'b0; i_rd_ready = 1'b0;
    tick(); tick();

    // Reset values
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_empty", 32'(o_empty), 32'd1);
    check("rst_full", 32'(o_full), 32'd0);
    check("rst_almfull", 32'(o_almfull), 32'd0);
    check("rst_valid", 32'(o_rd_valid), 32'd0);
    check("rst_overflow", 32'(o_overflow), 32'd0);
    check("rst_timeout", 32'(o_timeout), 32'd0);
    check("rst_data", 32'(o_rd_data), 32'd0);
    i_nrst = 1'b1;
    tick();

    // Three frames; the first one must be visible the cycle after its push
    i_rx_word = 9'h041; i_rx_done = 1'b1;
    sb.push_back(11'h041);
    tick();
    check("lat_valid", 32'(o_rd_valid), 32'd1);
    check("lat_data", 32'(o_rd_data), 32'h041);
    i_rx_done = 1'b0;
    tick();
    push(9'h142, 1'b0, 1'b0, 1'b1);
    push(9'h043, 1'b0, 1'b0, 1'b1);
    check("three_count", 32'(o_count), 32'd3);
    check("three_head", 32'(o_rd_data), 32'h041);
    drain("three");

    // Done held high for five cycles gives one entry
    i_rx_word = 9'h0A5; i_rx_done = 1'b1;
    sb.push_back(11'h0A5);
    repeat (5) tick();
    i_rx_done = 1'b0;
    tick();
    check("hold_count", 32'(o_count), 32'd1);
    drain("hold");

    // Almost-full, full, overflow, sticky until flush
    for (int i = 0; i < 11; i++) push(9'(i + 16), 1'b0, 1'b0, 1'b1);
    check("alm_11", 32'(o_almfull), 32'd0);
    push(9'h11B, 1'b0, 1'b0, 1'b1);
    check("alm_12", 32'(o_almfull), 32'd1);
    check("full_12", 32'(o_full), 32'd0);
    for (int i = 0; i < 4; i++) push(9'(i + 64), 1'b0, 1'b0, 1'b1);
    check("full_16", 32'(o_full), 32'd1);
    check("ovf_before", 32'(o_overflow), 32'd0);
    push(9'h1FF, 1'b1, 1'b0, 1'b0);
    check("ovf_set", 32'(o_overflow), 32'd1);
    check("ovf_count", 32'(o_count), 32'd16);
    check("ovf_head", 32'(o_rd_data), 32'(sb[0]));
    i_rd_ready = 1'b1; tick(); i_rd_ready = 1'b0;
    void'(sb.pop_front());
    check("ovf_sticky", 32'(o_overflow), 32'd1);
    check("pop_count", 32'(o_count), 32'd15);
    check("pop_head", 32'(o_rd_data), 32'(sb[0]));
    i_flush = 1'b1; tick(); i_flush = 1'b0;
    sb.delete();
    check("flush_ovf", 32'(o_overflow), 32'd0);
    check("flush_count", 32'(o_count), 32'd0);
    check("flush_empty", 32'(o_empty), 32'd1);

    // Full FIFO with push and pop in the same cycle
    for (int i = 0; i < 16; i++) push(9'(i + 128), 1'b0, 1'b0, 1'b1);
    check("pp_full", 32'(o_full), 32'd1);
    i_rx_word = 9'h1C3; i_rx_frame_error = 1'b0; i_rx_parity_error = 1'b0;
    i_rx_done = 1'b1; i_rd_ready = 1'b1;
    tick();
    i_rx_done = 1'b0; i_rd_ready = 1'b0;
    void'(sb.pop_front());
    sb.push_back(11'h1C3);
    check("pp_count", 32'(o_count), 32'd16);
    check("pp_ovf", 32'(o_overflow), 32'd0);
    check("pp_full_hold", 32'(o_full), 32'd1);
    tick();
    drain("pp");

    // Error flags with parity checking off, then on
    i_parity_enable = 1'b0;
    push(9'h055, 1'b1, 1'b1, 1'b1);
    check("err_pen0", 32'(o_rd_data[10:9]), 32'd1);
    i_parity_enable = 1'b1;
    push(9'h0AA, 1'b1, 1'b1, 1'b1);
    drain("err");
    push(9'h0AB, 1'b1, 1'b1, 1'b1);
    check("err_pen1", 32'(o_rd_data[10:9]), 32'd3);
    drain("err2");

    // A push in the flush cycle is ignored, and a done level still high afterwards does not re-push
    i_rx_word = 9'h033; i_rx_done = 1'b1; i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    tick(); tick();
    i_rx_done = 1'b0;
    tick();
    check("flush_push_count", 32'(o_count), 32'd0);

    // Asynchronous reset mid-operation
    push(9'h011, 1'b0, 1'b0, 1'b1);
    push(9'h012, 1'b0, 1'b0, 1'b1);
    #2 i_nrst = 1'b0;
    #1;
    check("arst_count", 32'(o_count), 32'd0);
    check("arst_valid", 32'(o_rd_valid), 32'd0);
    check("arst_data", 32'(o_rd_data), 32'd0);
    sb.delete();
    tick();
    i_nrst = 1'b1;
    tick();

`ifdef UART_RX_FIFO_TIMEOUT_EN
    // Idle timeout: one entry pending, 9-clock bit periods, 4 characters of 10 bits each
    begin
      int n;
      i_bit_length = 32'd8;
      push(9'h077, 1'b0, 1'b0, 1'b1);
      n = 1;
      for (int i = 0; i < 600; i++) begin
        if (o_timeout) break;
        tick();
        n++;
      end
      check("to_asserted", 32'(o_timeout), 32'd1);
      check("to_window", 32'(n >= 270 && n <= 450), 32'd1);
      i_rd_ready = 1'b1; tick(); i_rd_ready = 1'b0;
      void'(sb.pop_front());
      check("to_clear", 32'(o_timeout), 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
